part_select_reader: RTL and testbench
=====================================

PART_SELECT_READER -- requirements
Module: part_select_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning source word width; must be a power of two, at least 2.
REQ-002 SHALL have parameter SLICE, default 4, meaning emitted slice width; range 1..WIDTH.
REQ-003 SHALL have parameter CTRLW, default $clog2(WIDTH), meaning bit-offset and stride width.
REQ-004 SHALL have parameter CNTW, default 8, meaning slice-count width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port load_valid, input, 1 bit: job request.
REQ-008 SHALL have port load_ready, output, 1 bit: block accepts a job.
REQ-009 SHALL have port load_word, input, WIDTH bits: word to read slices from.
REQ-010 SHALL have port load_base, input, CTRLW bits: bit offset of the first slice.
REQ-011 SHALL have port load_stride, input, CTRLW bits: offset increment between slices.
REQ-012 SHALL have port load_count, input, CNTW bits: number of slices to emit.
REQ-013 SHALL have port out_valid, output, 1 bit: slice available.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the slice.
REQ-015 SHALL have port out_data, output, SLICE bits: current slice.
REQ-016 SHALL have port out_last, output, 1 bit: marks the final slice of a job.
REQ-017 SHALL have port busy, output, 1 bit: high while in EMIT.

Function
REQ-018 SHALL implement an FSM with two states: IDLE and EMIT.
REQ-019 SHALL drive load_ready high exactly when the state is IDLE.
REQ-020 SHALL treat a job as accepted on a cycle where load_valid and load_ready are both high, registering word, pos=load_base, stride and remaining=load_count.
REQ-021 SHALL, when an accepted job has load_count==0, stay in IDLE and emit nothing.
REQ-022 SHALL otherwise enter EMIT, so out_valid rises in the cycle after acceptance (latency 1).
REQ-023 SHALL drive out_data, in EMIT, from word[pos +: SLICE]; any bit index at or above WIDTH SHALL read as 0 (zero-fill, no wrap within a slice).
REQ-024 SHALL drive out_valid high exactly when in EMIT.
REQ-025 SHALL drive out_last high when in EMIT and remaining==1.
REQ-026 SHALL keep out_data and out_last stable while out_valid is high and out_ready is low.
REQ-027 SHALL, on a handshake (out_valid and out_ready both high), set pos to (pos+stride) mod WIDTH (natural CTRLW wrap) and decrement remaining.
REQ-028 SHALL, on a handshake with out_last high, return to IDLE; the next job can be accepted no earlier than the following cycle (one bubble).
REQ-029 SHALL ignore load_valid while in EMIT; load_* inputs SHALL have no effect on the job in progress.
REQ-030 SHALL allow stride==0, which repeats the same slice count times.
REQ-031 SHALL drive busy high exactly when in EMIT.

Reset
REQ-032 SHALL, when rst_n is low at a clock edge, force the state to IDLE, pos to 0, remaining to 0 and word to 0.
REQ-033 SHALL hold the following values during and after reset: out_valid=0, out_last=0, out_data=0, busy=0, load_ready=1 from the first cycle after reset.
REQ-034 SHALL, on reset during EMIT, abandon the job with no further slices emitted.

Structure
REQ-035 SHALL place the state enum (IDLE, EMIT) in the shared package part_select_pkg.
REQ-036 SHALL implement zero-fill extraction in the combinational sub-module slice_extract (parameters WIDTH, SLICE, CTRLW; ports word, pos, data).
REQ-037 SHALL use registered control only, with no combinational path from load_* to out_*.

Verification
REQ-038 SHALL cover the basic job: word=0x8765_4321, base=0, stride=4, count=3, out_ready=1 -> slices 0x1, 0x2, 0x3 on consecutive cycles, with last on 0x3.
REQ-039 SHALL cover zero-fill: word=0xF000_0000, base=30, SLICE=4, count=1 -> out_data=0x3, last=1.
REQ-040 SHALL cover offset wrap: word=0x0000_00A5, base=28, stride=4, count=3 -> slices 0x0, 0x5, 0xA.
REQ-041 SHALL cover backpressure: out_ready low for 3 cycles on the first slice -> out_data held at its value, pos not advanced, no slice lost.
REQ-042 SHALL cover the count=0 case and the load-during-EMIT case: a count=0 job -> no out_valid, load_ready stays high; a second load_valid during EMIT -> ignored until IDLE.
REQ-043 SHALL cover reset mid-job: rst_n low during the 2nd of 4 slices -> next cycle out_valid=0, load_ready=1, and a new job then starts cleanly.

Source files
------------

// File: rtl/part_select_pkg.sv
// Shared types for the part-select reader: controller state encoding.
package part_select_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/slice_extract.sv
// Combinational slice extraction: data = word[pos +: SLICE], bits past the top of word read 0.
module slice_extract #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4,
    parameter int CTRLW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word,
    input  logic [CTRLW-1:0] pos,
    output logic [SLICE-1:0] data
);

    // WIDTH is a power of two, so the carry bit of pos+i flags an index past the top.
    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        logic [CTRLW:0] idx;
        assign idx     = {1'b0, pos} + (CTRLW+1)'(i);
        assign data[i] = idx[CTRLW] ? 1'b0 : word[idx[CTRLW-1:0]];
    end

endmodule

// File: rtl/part_select_reader.sv
// Accepts a word plus base/stride/count and streams count slices over a valid/ready port.
module part_select_reader
    import part_select_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4,
    parameter int CTRLW = $clog2(WIDTH),
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_word,
    input  logic [CTRLW-1:0] load_base,
    input  logic [CTRLW-1:0] load_stride,
    input  logic [CNTW-1:0]  load_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SLICE-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] word_q;
    logic [CTRLW-1:0] pos_q;
    logic [CTRLW-1:0] stride_q;
    logic [CNTW-1:0]  rem_q;
    logic [SLICE-1:0] slice;
    logic             emit;
    logic             accept;
    logic             fire;

    assign emit       = (state == EMIT);
    assign load_ready = (state == IDLE);
    assign accept     = load_valid && load_ready;
    assign fire       = out_valid && out_ready;

    slice_extract #(
        .WIDTH(WIDTH),
        .SLICE(SLICE),
        .CTRLW(CTRLW)
    ) u_extract (
        .word(word_q),
        .pos (pos_q),
        .data(slice)
    );

    // Outputs depend only on registered state, never on load_*.
    assign out_valid = emit;
    assign busy      = emit;
    assign out_last  = emit && (rem_q == CNTW'(1));
    assign out_data  = emit ? slice : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_q   <= '0;
            pos_q    <= '0;
            stride_q <= '0;
            rem_q    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                word_q   <= load_word;
                pos_q    <= load_base;
                stride_q <= load_stride;
                rem_q    <= load_count;
            end else if (fire) begin
                pos_q <= pos_q + stride_q;
                rem_q <= rem_q - CNTW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && load_count != '0) state_nx = EMIT;
            EMIT: if (fire && out_last)           state_nx = IDLE;
            default:                              state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_part_select_reader.sv
// Randomized and directed checks of part_select_reader against a shift-based slice model.
module tb_part_select_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_word;
    logic [4:0]  load_base;
    logic [4:0]  load_stride;
    logic [7:0]  load_count;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_last;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    part_select_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_word  (load_word),
        .load_base  (load_base),
        .load_stride(load_stride),
        .load_count (load_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: slice k comes from bit offset (base + k*stride) mod 32, zero-filled above bit 31.
    function automatic logic [3:0] ref_slice(input logic [31:0] w, input int base,
                                             input int stride, input int k);
        logic [63:0] x;
        int          p;
        p = (base + k * stride) % 32;
        x = {32'b0, w} >> p;
        return x[3:0];
    endfunction

    // Called at a negedge with the DUT idle. stall_first holds out_ready low on the first slice.
    task automatic do_job(input logic [31:0] w, input int base, input int stride, input int cnt,
                          input int stall_pct, input int stall_first);
        int k;
        int held;
        int budget;
        chk("idle_ready", load_ready, 1);
        load_valid  = 1'b1;
        load_word   = w;
        load_base   = 5'(base);
        load_stride = 5'(stride);
        load_count  = 8'(cnt);
        @(negedge clk);
        load_valid = 1'b0;
        if (cnt == 0) begin
            chk("cnt0_valid", out_valid, 0);
            chk("cnt0_ready", load_ready, 1);
            return;
        end
        k      = 0;
        held   = 0;
        budget = 400;
        while (k < cnt && budget > 0) begin
            budget--;
            chk("valid", out_valid, 1);
            chk("busy", busy, 1);
            chk("ld_ready_emit", load_ready, 0);
            chk("data", out_data, ref_slice(w, base, stride, k));
            chk("last", out_last, (k == cnt - 1));
            // Garbage loads while emitting must not disturb the job.
            load_valid  = $urandom_range(1);
            load_word   = $urandom;
            load_base   = 5'($urandom);
            load_stride = 5'($urandom);
            load_count  = 8'($urandom);
            if (k == 0 && held < stall_first) begin
                out_ready = 1'b0;
                held++;
            end else begin
                out_ready = ($urandom_range(99) >= stall_pct);
            end
            @(negedge clk);
            if (out_ready) k++;
        end
        if (budget == 0) chk("timeout", 0, 1);
        load_valid = 1'b0;
        out_ready  = 1'b1;
        chk("done_valid", out_valid, 0);
        chk("done_ready", load_ready, 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        load_valid  = 1'b0;
        load_word   = '0;
        load_base   = '0;
        load_stride = '0;
        load_count  = '0;
        out_ready   = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", load_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        do_job(32'h8765_4321, 0, 4, 3, 0, 0);
        do_job(32'hF000_0000, 30, 0, 1, 0, 0);
        do_job(32'h0000_00A5, 28, 4, 3, 0, 0);
        do_job(32'h8765_4321, 4, 8, 3, 0, 3);
        do_job(32'h1234_5678, 0, 4, 0, 0, 0);
        do_job(32'hDEAD_BEEF, 8, 0, 4, 0, 0);

        // Reset while the 2nd of 4 slices is presented.
        load_valid  = 1'b1;
        load_word   = 32'h8765_4321;
        load_base   = 5'd0;
        load_stride = 5'd4;
        load_count  = 8'd4;
        out_ready   = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        chk("mid_s1", out_data, 4'h1);
        @(negedge clk);
        chk("mid_s2", out_data, 4'h2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", load_ready, 1);
        chk("mid_rst_data", out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", out_valid, 0);
        do_job(32'hCAFE_F00D, 12, 4, 4, 0, 0);

        for (int j = 0; j < 40; j++) begin
            do_job($urandom, $urandom_range(31), $urandom_range(31), $urandom_range(7),
                   $urandom_range(60), $urandom_range(2));
            repeat ($urandom_range(1)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
